// File: rtl/jk_pkg.sv
// JK flip-flop command vocabulary shared by the counter and its cells.
// A command names the intended transition of one state bit; the helper
// functions translate it to the physical J/K pin pair.
package jk_pkg;

  // Two-bit command; the encoding deliberately equals {j,k}.
  typedef enum logic [1:0] {
    HOLD   = 2'b00,
    RESET  = 2'b01,
    SET    = 2'b10,
    TOGGLE = 2'b11
  } jk_cmd_t;

  // Map a command to the {j,k} pin pair driven into a jk_cell.
  function automatic logic [1:0] jk_cmd_to_jk(input jk_cmd_t cmd);
    logic [1:0] jk_bits;
    case (cmd)
      HOLD:    jk_bits = 2'b00;
      RESET:   jk_bits = 2'b01;
      SET:     jk_bits = 2'b10;
      TOGGLE:  jk_bits = 2'b11;
      default: jk_bits = 2'b00;
    endcase
    return jk_bits;
  endfunction

  // Command that forces a bit to a known value regardless of its present state.
  function automatic jk_cmd_t jk_cmd_force(input logic bit_value);
    jk_cmd_t cmd;
    if (bit_value) begin
      cmd = SET;
    end else begin
      cmd = RESET;
    end
    return cmd;
  endfunction

endpackage

// File: rtl/jk_cell.sv
// Single JK flip-flop holding one counter state bit.
// Asynchronous active-low reset clears the bit to 0.
module jk_cell
  import jk_pkg::*;
(
  input  logic clk,
  input  logic RESET_N,
  input  logic j,
  input  logic k,
  output logic q
);

  // JK transition table: hold, reset, set, toggle.
  always_ff @(posedge clk or negedge RESET_N) begin
    if (!RESET_N) begin
      q <= 1'b0;
    end else begin
      case ({j, k})
        2'b00:   q <= q;
        2'b01:   q <= 1'b0;
        2'b10:   q <= 1'b1;
        2'b11:   q <= ~q;
        default: q <= q;
      endcase
    end
  end

endmodule

// File: rtl/jk_sync_counter.sv
// Synchronous modulo-N up/down counter built from JK flip-flops.
// The state lives only in the jk_cell instances; this module decides, per
// bit, which JK command produces the next count, and registers the wrap
// pulse. Priority per cycle is clr > load > en > hold.
module jk_sync_counter
  import jk_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 10
) (
  input  logic             clk,
  input  logic             RESET_N,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic             clr,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             wrap
);

  // Highest legal count, and the modulus widened so 2**WIDTH fits.
  localparam logic [WIDTH-1:0] MAX_Q   = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULUS);

  jk_cmd_t          cmd_s [WIDTH];
  logic [WIDTH-1:0] j_s;
  logic [WIDTH-1:0] k_s;
  logic [WIDTH-1:0] load_target_s;
  logic             wrap_next_s;
  logic             wrap_r;

  // Clamp an out-of-range load value to the top legal count.
  always_comb begin
    load_target_s = MAX_Q;
    if ({1'b0, d} < MOD_EXT) begin
      load_target_s = d;
    end else begin
      load_target_s = MAX_Q;
    end
  end

  // Per-bit JK command selection and wrap detection.
  always_comb begin
    logic ripple;
    ripple      = 1'b1;
    wrap_next_s = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      cmd_s[i] = HOLD;
    end

    if (clr) begin
      for (int i = 0; i < WIDTH; i++) begin
        cmd_s[i] = RESET;
      end
    end else if (load) begin
      for (int i = 0; i < WIDTH; i++) begin
        cmd_s[i] = jk_cmd_force(load_target_s[i]);
      end
    end else if (en) begin
      if (up) begin
        if (q >= MAX_Q) begin
          // Top of range (or an illegal value above it): return to zero.
          // Only bits that are currently 1 need a RESET.
          for (int i = 0; i < WIDTH; i++) begin
            if (q[i]) begin
              cmd_s[i] = RESET;
            end else begin
              cmd_s[i] = HOLD;
            end
          end
          wrap_next_s = 1'b1;
        end else begin
          // Binary increment: a bit toggles when every lower bit is 1.
          for (int i = 0; i < WIDTH; i++) begin
            if (ripple) begin
              cmd_s[i] = TOGGLE;
            end else begin
              cmd_s[i] = HOLD;
            end
            ripple = ripple & q[i];
          end
        end
      end else begin
        if (q == {WIDTH{1'b0}}) begin
          // Underflow from zero wraps to the top count.
          for (int i = 0; i < WIDTH; i++) begin
            cmd_s[i] = jk_cmd_force(MAX_Q[i]);
          end
          wrap_next_s = 1'b1;
        end else if (q > MAX_Q) begin
          // Illegal value: recover to the top count without flagging a wrap.
          for (int i = 0; i < WIDTH; i++) begin
            cmd_s[i] = jk_cmd_force(MAX_Q[i]);
          end
        end else begin
          // Binary decrement: a bit toggles when every lower bit is 0.
          for (int i = 0; i < WIDTH; i++) begin
            if (ripple) begin
              cmd_s[i] = TOGGLE;
            end else begin
              cmd_s[i] = HOLD;
            end
            ripple = ripple & ~q[i];
          end
        end
      end
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        cmd_s[i] = HOLD;
      end
    end
  end

  // Translate the per-bit commands into J/K pin levels.
  always_comb begin
    logic [1:0] jk_bits;
    j_s = {WIDTH{1'b0}};
    k_s = {WIDTH{1'b0}};
    for (int i = 0; i < WIDTH; i++) begin
      jk_bits = jk_cmd_to_jk(cmd_s[i]);
      j_s[i]  = jk_bits[1];
      k_s[i]  = jk_bits[0];
    end
  end

  // One JK flip-flop per state bit.
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cell
    jk_cell u_cell (
      .clk     (clk),
      .RESET_N (RESET_N),
      .j       (j_s[gi]),
      .k       (k_s[gi]),
      .q       (q[gi])
    );
  end

  // Wrap pulse: high for the cycle following each wrapping edge.
  always_ff @(posedge clk or negedge RESET_N) begin
    if (!RESET_N) begin
      wrap_r <= 1'b0;
    end else begin
      wrap_r <= wrap_next_s;
    end
  end

  assign wrap = wrap_r;

  // Terminal count looks only at the count direction, never at load/clr.
  assign tc = en & (up ? (q == MAX_Q) : (q == {WIDTH{1'b0}}));

endmodule

// File: tb/tb_jk_sync_counter.sv
// Self-checking bench for jk_sync_counter: a decimal instance (default
// parameters) and a full-range hex instance, both checked against an
// arithmetic reference model of the counting rules.
module tb_jk_sync_counter;

  logic       clk;
  logic       RESET_N;
  logic       en, up, load, clr;
  logic [3:0] d;
  logic [3:0] q;
  logic       tc, wrap;
  logic       en16, up16, load16, clr16;
  logic [3:0] d16;
  logic [3:0] q16;
  logic       tc16, wrap16;

  int errors;
  int checks;
  int m_q, m_wrap, m16_q, m16_wrap;

  jk_sync_counter dut (
    .clk(clk), .RESET_N(RESET_N), .en(en), .up(up), .load(load), .clr(clr),
    .d(d), .q(q), .tc(tc), .wrap(wrap)
  );

  jk_sync_counter #(.WIDTH(4), .MODULUS(16)) dut16 (
    .clk(clk), .RESET_N(RESET_N), .en(en16), .up(up16), .load(load16), .clr(clr16),
    .d(d16), .q(q16), .tc(tc16), .wrap(wrap16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference rules written as plain arithmetic on integers.
  function automatic void model_next(input int cq, input int e, input int u, input int ld,
                                     input int cl, input int dv, input int modn,
                                     output int nq, output int nw);
    nq = cq;
    nw = 0;
    if (cl != 0) begin
      nq = 0;
    end else if (ld != 0) begin
      nq = (dv < modn) ? dv : modn - 1;
    end else if (e != 0) begin
      if (u != 0) begin
        if (cq >= modn - 1) begin nq = 0; nw = 1; end
        else nq = cq + 1;
      end else begin
        if (cq == 0) begin nq = modn - 1; nw = 1; end
        else if (cq >= modn) nq = modn - 1;
        else nq = cq - 1;
      end
    end
  endfunction

  function automatic int model_tc(input int cq, input int e, input int u, input int modn);
    if (e == 0) return 0;
    return (u != 0) ? int'(cq == modn - 1) : int'(cq == 0);
  endfunction

  // Advance one clock edge, updating both models; returns 1 ns after the edge.
  task automatic step();
    int nq, nw, nq16, nw16;
    model_next(m_q, int'(en), int'(up), int'(load), int'(clr), int'(d), 10, nq, nw);
    model_next(m16_q, int'(en16), int'(up16), int'(load16), int'(clr16), int'(d16), 16, nq16, nw16);
    @(posedge clk);
    #1;
    if (RESET_N !== 1'b1) begin
      nq = 0; nw = 0; nq16 = 0; nw16 = 0;
    end
    m_q = nq; m_wrap = nw; m16_q = nq16; m16_wrap = nw16;
  endtask

  task automatic idle_inputs();
    en = 1'b0; up = 1'b1; load = 1'b0; clr = 1'b0; d = 4'd0;
    en16 = 1'b0; up16 = 1'b1; load16 = 1'b0; clr16 = 1'b0; d16 = 4'd0;
  endtask

  task automatic test_reset();
    RESET_N = 1'b0;
    en = 1'b1; up = 1'b1;
    step(); step();
    checks++; if (q !== 4'd0) begin errors++; $display("FAIL reset_q: got %0d want 0", q); end
    checks++; if (wrap !== 1'b0) begin errors++; $display("FAIL reset_wrap: got %0b want 0", wrap); end
    checks++; if (tc !== 1'b0) begin errors++; $display("FAIL reset_tc_up: got %0b want 0", tc); end
    checks++; if (q16 !== 4'd0) begin errors++; $display("FAIL reset_q16: got %0d want 0", q16); end
    up = 1'b0;
    #1;
    checks++; if (tc !== 1'b1) begin errors++; $display("FAIL reset_tc_down: got %0b want 1", tc); end
    up = 1'b1;
    RESET_N = 1'b1;
  endtask

  task automatic test_count_up();
    en = 1'b1; up = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step();
      checks++;
      if (int'(q) !== (i + 1) % 10) begin
        errors++; $display("FAIL count_up_q[%0d]: got %0d want %0d", i, q, (i + 1) % 10);
      end
      checks++;
      if (int'(wrap) !== m_wrap) begin
        errors++; $display("FAIL count_up_wrap[%0d]: got %0b want %0d", i, wrap, m_wrap);
      end
    end
    en = 1'b0;
  endtask

  task automatic test_count_down();
    clr = 1'b1; step(); clr = 1'b0;
    en = 1'b1; up = 1'b0;
    #1;
    checks++; if (tc !== 1'b1) begin errors++; $display("FAIL down_tc_at_zero: got %0b want 1", tc); end
    step();
    checks++; if (q !== 4'd9) begin errors++; $display("FAIL down_wrap_q: got %0d want 9", q); end
    checks++; if (wrap !== 1'b1) begin errors++; $display("FAIL down_wrap_pulse: got %0b want 1", wrap); end
    en = 1'b0;
    step();
    checks++; if (wrap !== 1'b0) begin errors++; $display("FAIL down_wrap_clear: got %0b want 0", wrap); end
    checks++; if (q !== 4'd9) begin errors++; $display("FAIL down_hold_q: got %0d want 9", q); end
    up = 1'b1;
  endtask

  task automatic test_load();
    load = 1'b1; d = 4'd7; step();
    checks++; if (q !== 4'd7) begin errors++; $display("FAIL load_7: got %0d want 7", q); end
    d = 4'd13; step();
    checks++; if (q !== 4'd9) begin errors++; $display("FAIL load_clamp: got %0d want 9", q); end
    clr = 1'b1; d = 4'd5; step();
    checks++; if (q !== 4'd0) begin errors++; $display("FAIL load_clr_prio: got %0d want 0", q); end
    checks++; if (wrap !== 1'b0) begin errors++; $display("FAIL load_clr_wrap: got %0b want 0", wrap); end
    clr = 1'b0; load = 1'b0;
  endtask

  task automatic test_priority();
    load = 1'b1; d = 4'd4; step();
    en = 1'b1; up = 1'b1; d = 4'd2; step();
    checks++; if (q !== 4'd2) begin errors++; $display("FAIL load_over_en: got %0d want 2", q); end
    load = 1'b0; en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (q !== 4'd2) begin errors++; $display("FAIL hold_q[%0d]: got %0d want 2", i, q); end
      checks++; if (tc !== 1'b0) begin errors++; $display("FAIL hold_tc[%0d]: got %0b want 0", i, tc); end
    end
  endtask

  task automatic test_async_reset();
    load = 1'b1; d = 4'd5; step();
    load = 1'b0; en = 1'b1; up = 1'b1;
    #1 RESET_N = 1'b0;
    #1;
    checks++; if (q !== 4'd0) begin errors++; $display("FAIL async_q: got %0d want 0", q); end
    checks++; if (wrap !== 1'b0) begin errors++; $display("FAIL async_wrap: got %0b want 0", wrap); end
    #2 RESET_N = 1'b1;
    m_q = 0; m_wrap = 0; m16_q = 0; m16_wrap = 0;
    step();
    checks++; if (q !== 4'd1) begin errors++; $display("FAIL async_first_step: got %0d want 1", q); end
    en = 1'b0;
  endtask

  task automatic test_back_to_back();
    clr = 1'b1; step(); clr = 1'b0;
    en = 1'b1; up = 1'b0; step();
    checks++; if (q !== 4'd9 || wrap !== 1'b1) begin
      errors++; $display("FAIL b2b_first: got q=%0d wrap=%0b want q=9 wrap=1", q, wrap);
    end
    up = 1'b1; step();
    checks++; if (q !== 4'd0 || wrap !== 1'b1) begin
      errors++; $display("FAIL b2b_second: got q=%0d wrap=%0b want q=0 wrap=1", q, wrap);
    end
    en = 1'b0; step();
    checks++; if (wrap !== 1'b0) begin errors++; $display("FAIL b2b_end: got %0b want 0", wrap); end
  endtask

  task automatic test_mod16();
    load16 = 1'b1; d16 = 4'd13; step(); load16 = 1'b0;
    checks++; if (int'(q16) !== m16_q) begin errors++; $display("FAIL m16_load: got %0d want %0d", q16, m16_q); end
    en16 = 1'b1; up16 = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (i == 5) up16 = 1'b0;
      #1;
      checks++;
      if (int'(tc16) !== model_tc(m16_q, 1, int'(up16), 16)) begin
        errors++; $display("FAIL m16_tc[%0d]: got %0b", i, tc16);
      end
      step();
      checks++;
      if (int'(q16) !== m16_q || int'(wrap16) !== m16_wrap) begin
        errors++; $display("FAIL m16_step[%0d]: got q=%0d wrap=%0b want q=%0d wrap=%0d",
                           i, q16, wrap16, m16_q, m16_wrap);
      end
    end
    en16 = 1'b0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      en   = 1'($urandom_range(0, 3) != 0);
      up   = 1'($urandom_range(0, 1));
      load = 1'($urandom_range(0, 7) == 0);
      clr  = 1'($urandom_range(0, 15) == 0);
      d    = 4'($urandom_range(0, 15));
      #1;
      checks++;
      if (int'(tc) !== model_tc(m_q, int'(en), int'(up), 10)) begin
        errors++; $display("FAIL rand_tc[%0d]: got %0b q=%0d", i, tc, q);
      end
      step();
      checks++;
      if (int'(q) !== m_q || int'(wrap) !== m_wrap) begin
        errors++; $display("FAIL rand_step[%0d]: got q=%0d wrap=%0b want q=%0d wrap=%0d",
                           i, q, wrap, m_q, m_wrap);
      end
    end
    idle_inputs();
  endtask

  initial begin
    errors = 0; checks = 0;
    m_q = 0; m_wrap = 0; m16_q = 0; m16_wrap = 0;
    RESET_N = 1'b0;
    idle_inputs();
    test_reset();
    test_count_up();
    test_count_down();
    test_load();
    test_priority();
    test_async_reset();
    test_back_to_back();
    test_mod16();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/jk_sync_counter.md
JK_SYNC_COUNTER -- requirements
Module: jk_sync_counter

Interface
REQ-001 Parameter WIDTH, default 4, counter bit width.
REQ-002 Parameter MODULUS, default 10, count states 0..MODULUS-1; 2 <= MODULUS <= 2**WIDTH.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 RESET_N  input  1  reset, asynchronous, active-low.
REQ-005 en  input  1  count enable; high advances count one step per cycle.
REQ-006 up  input  1  direction; 1 = increment, 0 = decrement.
REQ-007 load  input  1  synchronous parallel load of d.
REQ-008 clr  input  1  synchronous clear to 0.
REQ-009 d  input  WIDTH  parallel load value.
REQ-010 q  output  WIDTH  current count, one jk_cell output per bit.
REQ-011 tc  output  1  terminal count, combinational.
REQ-012 wrap  output  1  registered one-cycle pulse after a wrap.

Function
REQ-013 State bits SHALL be held in WIDTH jk_cell instances; next state SHALL be produced only by driving each cell's J/K with HOLD (0,0), RESET (0,1), SET (1,0) or TOGGLE (1,1).
REQ-014 Per-cycle priority SHALL be clr > load > en > hold.
REQ-015 clr=1: every cell RESET; q=0 after the edge; wrap=0.
REQ-016 load=1, clr=0: each bit SET if target 1, RESET if 0; target = d if d < MODULUS, else MODULUS-1 (clamp); wrap=0.
REQ-017 en=1, up=1, q < MODULUS-1: q becomes q+1; bit i TOGGLE iff bits 0..i-1 all 1.
REQ-018 en=1, up=1, q = MODULUS-1: q becomes 0 (cells set to RESET/HOLD as needed); wrap=1 next cycle.
REQ-019 en=1, up=0, q > 0: q becomes q-1; bit i TOGGLE iff bits 0..i-1 all 0.
REQ-020 en=1, up=0, q = 0: q becomes MODULUS-1; wrap=1 next cycle.
REQ-021 en=0, load=0, clr=0: all cells HOLD; q unchanged; wrap=0.
REQ-022 tc SHALL be en & (up ? q==MODULUS-1 : q==0); it SHALL be independent of load/clr.
REQ-023 wrap SHALL be high for exactly one cycle following each wrap edge; back-to-back wraps (MODULUS=2 region not applicable, but consecutive wrap cycles e.g. direction flip) SHALL give wrap high on each following cycle.
REQ-024 Changing up while en=1 SHALL take effect on the same edge; no extra latency.
REQ-025 If q ever holds a value >= MODULUS (non-power-of-2 modulus), up-count SHALL go to 0 with wrap, down-count SHALL go to MODULUS-1 with no wrap.
REQ-026 Count latency: q reflects a step on the rising edge where en sampled high; no pipeline.

Reset
REQ-027 RESET_N low SHALL asynchronously force q=0 and wrap=0, regardless of clk.
REQ-028 RESET_N asserted mid-count SHALL abort the step; first step after release occurs at the first rising edge with RESET_N high and en=1.
REQ-029 tc during reset follows REQ-022 with q=0.

Structure
REQ-030 Package jk_pkg SHALL hold the 2-bit JK command enum (HOLD, RESET, SET, TOGGLE) and a function mapping command to {j,k}.
REQ-031 Sub-module jk_cell SHALL be one JK flip-flop (ports clk, RESET_N, j, k, q), asynchronous active-low reset to 0; jk_sync_counter SHALL contain only next-state J/K logic, the wrap register and WIDTH jk_cell instances.

Verification
REQ-032 RESET_N=0 with clk running, en=1 -> q=0, wrap=0; release, 12 cycles en=1 up=1 -> q 1..9,0,1,2; wrap high only on the cycle after 9->0.
REQ-033 q=0, en=1 up=0 -> q=9 next edge, wrap=1 one cycle, tc=1 while q=0 before the edge.
REQ-034 load=1 d=7 -> q=7; load=1 d=13 -> q=9 (clamp); load=1 with clr=1 same cycle -> q=0.
REQ-035 q=4, en=1, load=1 d=2 -> q=2 (load wins); then en=0 for 3 cycles -> q stays 2, tc=0.
REQ-036 q=5 counting up, RESET_N pulsed low for 3 ns between edges -> q=0 immediately, next enabled edge gives q=1.
REQ-037 WIDTH=4 MODULUS=16: up from 15 -> 0 with wrap=1; down from 0 -> 15 with wrap=1; every intermediate transition checked against q±1.
